// File: rtl/fifo_defs.sv
// -----------------------------------------------------------------------------
// fifo_defs
// Definitions shared by the FIFO storage bank and its pointer/flag controller:
// the default address width, the default almost_full / almost_empty levels and
// the depth constant 2**A.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_defs;

  localparam int FIFO_A        = 4;
  localparam int FIFO_AF_LEVEL = 14;
  localparam int FIFO_AE_LEVEL = 2;
  localparam int FIFO_DEPTH    = 2 ** FIFO_A;

  // Number of entries addressed by an a-bit pointer.
  function automatic int depth_of(input int a);
    return 2 ** a;
  endfunction

endpackage

// File: rtl/control_fifo_if.sv
// -----------------------------------------------------------------------------
// control_fifo_if
// Request/status bundle between a FIFO user and the control_fifo controller.
//   wr, rd                      : push / pop requests (user -> controller)
//   wr_en, address_w, address_r : storage bank controls (controller -> bank)
//   full, empty, almost_full,
//   almost_empty, count         : registered status (controller -> user)
//   overflow, underflow         : sticky error flags, present only when
//                                 FIFO_CTRL_ERR_EN is defined
// Modports: master = FIFO user, slave = controller.
// -----------------------------------------------------------------------------
interface control_fifo_if
  import fifo_defs::*;
#(
  parameter int A = FIFO_A
);

  logic         wr;
  logic         rd;
  logic         wr_en;
  logic [A-1:0] address_w;
  logic [A-1:0] address_r;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [A:0]   count;
`ifdef FIFO_CTRL_ERR_EN
  logic         overflow;
  logic         underflow;
`endif

  modport master (
    output wr, rd,
    input  wr_en, address_w, address_r, full, empty,
    input  almost_full, almost_empty, count
`ifdef FIFO_CTRL_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr, rd,
    output wr_en, address_w, address_r, full, empty,
    output almost_full, almost_empty, count
`ifdef FIFO_CTRL_ERR_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/puntero_fifo.sv
// -----------------------------------------------------------------------------
// puntero_fifo
// A-bit wrapping pointer register (2**A-1 -> 0) with an increment enable.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, pointer -> 0
//   i_inc : advance the pointer by one at this edge
//   o_ptr : current pointer value (registered)
// -----------------------------------------------------------------------------
module puntero_fifo
  import fifo_defs::*;
#(
  parameter int A = FIFO_A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [A-1:0] o_ptr
);

  logic [A-1:0] r_ptr;

  // Natural A-bit overflow gives the modulo-2**A wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + A'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/control_fifo.sv
// -----------------------------------------------------------------------------
// control_fifo
// Pointer/flag controller for a FIFO storage bank (one synchronous write port,
// one asynchronous read port). Holds no data; generates the bank write strobe
// and both addresses and keeps occupancy plus full/empty/almost flags.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (discards all contents)
//   bus   : control_fifo_if.slave (wr, rd in; wr_en, address_w, address_r,
//           full, empty, almost_full, almost_empty, count out)
// Optional: define FIFO_CTRL_ERR_EN to add sticky overflow/underflow outputs.
// -----------------------------------------------------------------------------
module control_fifo
  import fifo_defs::*;
#(
  parameter int A        = FIFO_A,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic          clk,
  input  logic          reset,
  control_fifo_if.slave bus
);

  localparam logic [A:0] C_DEPTH = (A+1)'(depth_of(A));
  localparam logic [A:0] C_AF    = (A+1)'(AF_LEVEL);
  localparam logic [A:0] C_AE    = (A+1)'(AE_LEVEL);

  logic         w_push;
  logic         w_pop;
  logic [A:0]   w_count_next;
  logic [1:0]   w_inc;
  logic [A-1:0] w_ptr [2];

  logic [A:0]   r_count;
  logic         r_full;
  logic         r_empty;
  logic         r_almost_full;
  logic         r_almost_empty;

  // A push is allowed into a full FIFO only when a pop frees the head slot in
  // the same cycle; a pop needs data to exist.
  assign w_push = bus.wr & (~r_full | bus.rd);
  assign w_pop  = bus.rd & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (A+1)'(1);
      2'b01:   w_count_next = r_count - (A+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Index 0 = write pointer, index 1 = read pointer.
  assign w_inc = {w_pop, w_push};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      puntero_fifo #(.A(A)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_inc[gi]),
        .o_ptr (w_ptr[gi])
      );
    end
  endgenerate

  // Flags come from the next count so they are exact in the same update as it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_next;
      r_full         <= (w_count_next == C_DEPTH);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= C_AF);
      r_almost_empty <= (w_count_next <= C_AE);
    end
  end

  // Held low during reset so the bank never writes a word that reset discards.
  assign bus.wr_en        = w_push & ~reset;
  assign bus.address_w    = w_ptr[0];
  assign bus.address_r    = w_ptr[1];
  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;

`ifdef FIFO_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr & r_full & ~bus.rd) r_overflow  <= 1'b1;
      if (bus.rd & r_empty)          r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule
